// File: rtl/spi_reg_controller.sv
// SPI mode-0 initiator issuing 16-bit register-write frames {write, addr[6:0], data[7:0]}, MSB first.
// Optional build macro SPI_CTRL_ADDR_CHECK_EN: writes to addresses above 7'h04 are rejected with an err pulse.
module spi_reg_controller #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       sclk,
  output logic       copi,
  output logic       cs_n,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP,
    REJECT
  } state_t;

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  state_t      state;
  logic [7:0]  half_cnt;
  logic [4:0]  bit_cnt;
  logic [15:0] shreg;
  logic        half_end;

  assign half_end = (half_cnt == HALF_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      half_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      req_ready <= 1'b1;
      sclk      <= 1'b0;
      copi      <= 1'b0;
      cs_n      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            half_cnt  <= '0;
            bit_cnt   <= '0;
`ifdef SPI_CTRL_ADDR_CHECK_EN
            if (req_write && (req_addr > 7'h04)) begin
              state <= REJECT;
              err   <= 1'b1;
            end else
`endif
            begin
              state <= SETUP;
              cs_n  <= 1'b0;
              copi  <= req_write;
              shreg <= {req_write, req_addr, req_data};
            end
          end
        end

        SETUP: begin
          if (half_end) begin
            half_cnt <= '0;
            sclk     <= 1'b1;
            state    <= SHIFT;
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end

        // Each bit period: high half, then falling edge shifts the next bit out;
        // the low half of bit 15 ends the shift phase.
        SHIFT: begin
          if (half_end) begin
            half_cnt <= '0;
            if (sclk) begin
              sclk  <= 1'b0;
              copi  <= shreg[14];
              shreg <= {shreg[14:0], 1'b0};
            end else if (bit_cnt == 5'd15) begin
              state <= HOLD;
            end else begin
              sclk    <= 1'b1;
              bit_cnt <= bit_cnt + 5'd1;
            end
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end

        HOLD: begin
          if (half_end) begin
            half_cnt <= '0;
            bit_cnt  <= '0;
            cs_n     <= 1'b1;
            copi     <= 1'b0;
            done     <= 1'b1;
            state    <= GAP;
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end

        // Gap spans two half-periods; bit_cnt[0] marks the second so the
        // 8-bit half counter never has to reach 2*CLK_DIV.
        GAP: begin
          if (half_end) begin
            half_cnt <= '0;
            if (bit_cnt[0]) begin
              bit_cnt   <= '0;
              busy      <= 1'b0;
              req_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              bit_cnt <= 5'd1;
            end
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end

        REJECT: begin
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          cs_n      <= 1'b1;
          sclk      <= 1'b0;
          copi      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_controller.sv
// Directed bench for spi_reg_controller: CLK_DIV=4 instance for frames/timing/reset/address check,
// CLK_DIV=2 instance for a read frame and SCLK period.
module tb_spi_reg_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n;
  logic       req_valid, req_ready, req_write;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       sclk, copi, cs_n, busy, done, err;

  logic       req_valid2, req_ready2, req_write2;
  logic [6:0] req_addr2;
  logic [7:0] req_data2;
  logic       sclk2, copi2, cs_n2, busy2, done2, err2;

  spi_reg_controller #(.CLK_DIV(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .sclk(sclk), .copi(copi), .cs_n(cs_n), .busy(busy), .done(done), .err(err)
  );

  spi_reg_controller #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_write(req_write2), .req_addr(req_addr2), .req_data(req_data2),
    .sclk(sclk2), .copi(copi2), .cs_n(cs_n2), .busy(busy2), .done(done2), .err(err2)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Peripheral-side deserialiser and register model for the CLK_DIV=4 instance.
  logic [15:0] frames_q[$];
  int          fall_q[$], rise_q[$], first_rise_q[$];
  int          done_cnt = 0, done_t = 0, aborts = 0, err_cnt = 0;
  logic [7:0]  regs[128];

  initial begin
    logic        prev_cs, prev_sclk;
    logic [15:0] sh;
    int          bits;
    prev_cs = 1'b1; prev_sclk = 1'b0; sh = '0; bits = 0;
    forever begin
      @(negedge clk);
      if (prev_cs === 1'b1 && cs_n === 1'b0) begin
        fall_q.push_back(cyc); bits = 0; sh = '0;
      end
      if (cs_n === 1'b0 && sclk === 1'b1 && prev_sclk === 1'b0) begin
        if (bits == 0) first_rise_q.push_back(cyc);
        sh = {sh[14:0], copi};
        bits++;
      end
      if (prev_cs === 1'b0 && cs_n === 1'b1) begin
        rise_q.push_back(cyc);
        if (bits == 16) begin
          frames_q.push_back(sh);
          if (sh[15]) regs[sh[14:8]] = sh[7:0];
        end else aborts++;
      end
      if (done === 1'b1) begin done_cnt++; done_t = cyc; end
      if (err === 1'b1) err_cnt++;
      prev_cs = cs_n; prev_sclk = sclk;
    end
  end

  // Deserialiser for the CLK_DIV=2 instance, tracking SCLK period extremes.
  logic [15:0] frame2 = '0;
  int          frame2_cnt = 0, fall2 = 0, rise2 = 0, per_min = 9999, per_max = 0;

  initial begin
    logic        prev_cs, prev_sclk;
    logic [15:0] sh;
    int          bits, last_rise;
    prev_cs = 1'b1; prev_sclk = 1'b0; sh = '0; bits = 0; last_rise = -1;
    forever begin
      @(negedge clk);
      if (prev_cs === 1'b1 && cs_n2 === 1'b0) begin
        fall2 = cyc; bits = 0; sh = '0; last_rise = -1;
      end
      if (cs_n2 === 1'b0 && sclk2 === 1'b1 && prev_sclk === 1'b0) begin
        if (last_rise >= 0) begin
          if (cyc - last_rise < per_min) per_min = cyc - last_rise;
          if (cyc - last_rise > per_max) per_max = cyc - last_rise;
        end
        last_rise = cyc;
        sh = {sh[14:0], copi2};
        bits++;
      end
      if (prev_cs === 1'b0 && cs_n2 === 1'b1) begin
        rise2 = cyc;
        if (bits == 16) begin frame2 = sh; frame2_cnt++; end
      end
      prev_cs = cs_n2; prev_sclk = sclk2;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_q();
    frames_q.delete(); fall_q.delete(); rise_q.delete(); first_rise_q.delete();
  endtask

  task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d, output int acc);
    int n;
    n = 0;
    req_write = w; req_addr = a; req_data = d; req_valid = 1'b1;
    while (!req_ready && n < 1000) begin tick(); n++; end
    if (!req_ready) check("accept_timeout", 0, 1);
    acc = cyc + 1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int start, input int budget);
    int n;
    n = 0;
    while (done_cnt == start && n < budget) begin tick(); n++; end
    if (done_cnt == start) check("done_timeout", 0, 1);
  endtask

  typedef struct {
    logic        w;
    logic [6:0]  a;
    logic [7:0]  d;
    logic [15:0] f;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int acc, acc2, dc0, n;
    for (int i = 0; i < 128; i++) regs[i] = 8'h00;
    vecs[0] = '{1'b1, 7'h02, 8'hA5, 16'h82A5};
    vecs[1] = '{1'b0, 7'h01, 8'h3C, 16'h013C};
    vecs[2] = '{1'b1, 7'h04, 8'h80, 16'h8480};
    vecs[3] = '{1'b0, 7'h7F, 8'h00, 16'h7F00};

    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
    req_valid2 = 1'b0; req_write2 = 1'b0; req_addr2 = '0; req_data2 = '0;
    tick(); tick(); tick();
    rst_n = 1'b1;

    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 0);
    check("rst_copi", copi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_req_ready", req_ready, 1);
    tick();

    foreach (vecs[i]) begin
      clear_q();
      dc0 = done_cnt;
      send(vecs[i].w, vecs[i].a, vecs[i].d, acc);
      check("busy_after_accept", busy, 1);
      check("ready_after_accept", req_ready, 0);
      wait_done(dc0, 400);
      tick();
      check("done_count", done_cnt - dc0, 1);
      check("frame_count", frames_q.size(), 1);
      if (frames_q.size() > 0) check("frame", frames_q[0], vecs[i].f);
      if (fall_q.size() > 0) check("cs_fall_cycle", fall_q[0] - acc, 0);
      if (rise_q.size() > 0 && fall_q.size() > 0) check("cs_low_len", rise_q[0] - fall_q[0], 136);
      if (first_rise_q.size() > 0) check("first_sclk_rise", first_rise_q[0] - acc, 4);
      check("done_cycle", done_t - acc, 136);
    end

    // Back-to-back with req_valid held high across the gap.
    n = 0;
    while (!req_ready && n < 400) begin tick(); n++; end
    clear_q();
    dc0 = done_cnt;
    req_write = 1'b1; req_addr = 7'h00; req_data = 8'hFF; req_valid = 1'b1;
    acc = cyc + 1;
    tick();
    req_addr = 7'h04; req_data = 8'h80;
    n = 0;
    while (!req_ready && n < 400) begin tick(); n++; end
    check("b2b_ready_seen", req_ready, 1);
    acc2 = cyc + 1;
    tick();
    req_valid = 1'b0;
    wait_done(dc0 + 1, 400);
    tick();
    check("b2b_accept_spacing", acc2 - acc, 145);
    check("b2b_frame_count", frames_q.size(), 2);
    if (frames_q.size() > 1) begin
      check("b2b_frame0", frames_q[0], 16'h80FF);
      check("b2b_frame1", frames_q[1], 16'h8480);
    end
    if (rise_q.size() > 0 && fall_q.size() > 1) check("b2b_cs_gap", fall_q[1] - rise_q[0], 9);

    // Register writes as the peripheral would apply them.
    dc0 = done_cnt;
    send(1'b1, 7'h00, 8'hF0, acc);
    wait_done(dc0, 400);
    dc0 = done_cnt;
    send(1'b1, 7'h04, 8'h40, acc);
    wait_done(dc0, 400);
    tick();
    check("reg00", regs[0], 8'hF0);
    check("reg04", regs[4], 8'h40);

    // Reset asserted mid-frame at cycle 60.
    dc0 = done_cnt;
    n = aborts;
    send(1'b1, 7'h00, 8'h11, acc);
    while (cyc < acc + 59) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_cs_n", cs_n, 1);
    check("midrst_sclk", sclk, 0);
    check("midrst_req_ready", req_ready, 1);
    check("midrst_busy", busy, 0);
    repeat (200) tick();
    check("midrst_no_done", done_cnt, dc0);
    check("midrst_abort", aborts - n, 1);
    check("midrst_reg00", regs[0], 8'hF0);

    // Write to address 0x05.
    clear_q();
    dc0 = done_cnt;
    n = err_cnt;
    send(1'b1, 7'h05, 8'h3C, acc);
`ifdef SPI_CTRL_ADDR_CHECK_EN
    check("addr_err_pulse", err, 1);
    check("addr_busy", busy, 1);
    check("addr_cs_n", cs_n, 1);
    tick();
    check("addr_ready_back", req_ready, 1);
    check("addr_err_clear", err, 0);
    check("addr_busy_clear", busy, 0);
    repeat (200) tick();
    check("addr_no_cs_fall", fall_q.size(), 0);
    check("addr_no_done", done_cnt, dc0);
    check("addr_err_count", err_cnt - n, 1);
`else
    check("addr_no_err", err, 0);
    wait_done(dc0, 400);
    tick();
    check("addr_frame_count", frames_q.size(), 1);
    if (frames_q.size() > 0) check("addr_frame", frames_q[0], 16'h853C);
    check("addr_err_count", err_cnt - n, 0);
`endif

    // CLK_DIV=2 read request on the second instance.
    req_write2 = 1'b0; req_addr2 = 7'h03; req_data2 = 8'h5A; req_valid2 = 1'b1;
    n = 0;
    while (!req_ready2 && n < 100) begin tick(); n++; end
    tick();
    req_valid2 = 1'b0;
    n = 0;
    while (frame2_cnt == 0 && n < 300) begin tick(); n++; end
    check("div2_frame_count", frame2_cnt, 1);
    check("div2_frame", frame2, 16'h035A);
    check("div2_period_min", per_min, 4);
    check("div2_period_max", per_max, 4);
    check("div2_cs_low_len", rise2 - fall2, 68);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
